// File: rtl/i2c_slave_data_path_block.sv
// I2C target datapath: line synchronizers, START/STOP detection, address match,
// byte receive/transmit with ACK handling and SCL-fall-relative SDA hold timing.
module i2c_slave_data_path_block #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter int unsigned SDA_HOLD   = 2
) (
    input  logic       i2c_core_clock_i,
    input  logic       reset_bit_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    input  logic       ack_en_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_load_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rw_o,
    output logic       busy_o,
    output logic       start_det_o,
    output logic       stop_det_o,
    output logic       nack_o
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StRx, StRxAck, StTx, StTxAck, StIgnore
    } state_e;

    localparam logic [3:0] HoldInit = 4'(SDA_HOLD);

    // [0],[1] synchronize; [2] is the previous synced value for edge detection
    logic [2:0] scl_sync_q, sda_sync_q;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic       sda_q, sda_d;
    logic       pend_q, pend_d;      // SDA value waiting for the hold time to expire
    logic [3:0] hold_q, hold_d;
    logic       ack_q, ack_d;        // ack_en_i as seen when the ACK slot was driven
    logic       rx_valid_q, rx_valid_d;
    logic       tx_load_q, tx_load_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       nack_q, nack_d;

    logic       scl_rise, scl_fall, scl_high, sda_s, start_c, stop_c;
    logic       drive, drive_val;
    logic [3:0] cnt_inc;

    assign sda_s    = sda_sync_q[1];
    assign scl_rise = scl_sync_q[1] & ~scl_sync_q[2];
    assign scl_fall = ~scl_sync_q[1] & scl_sync_q[2];
    assign scl_high = scl_sync_q[1] & scl_sync_q[2];
    assign start_c  = scl_high & ~sda_sync_q[1] & sda_sync_q[2];
    assign stop_c   = scl_high & sda_sync_q[1] & ~sda_sync_q[2];
    assign cnt_inc  = (cnt_q == 4'd8) ? cnt_q : cnt_q + 4'd1;

    // Line synchronizers and edge-detect history
    always_ff @(posedge i2c_core_clock_i or posedge reset_bit_i) begin
        if (reset_bit_i) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], scl_i};
            sda_sync_q <= {sda_sync_q[1:0], sda_i};
        end
    end

    // Controller state register
    always_ff @(posedge i2c_core_clock_i or posedge reset_bit_i) begin
        if (reset_bit_i) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            shift_q    <= 8'h00;
            tx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            sda_q      <= 1'b1;
            pend_q     <= 1'b1;
            hold_q     <= 4'd0;
            ack_q      <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            nack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            sda_q      <= sda_d;
            pend_q     <= pend_d;
            hold_q     <= hold_d;
            ack_q      <= ack_d;
            rx_valid_q <= rx_valid_d;
            tx_load_q  <= tx_load_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            nack_q     <= nack_d;
        end
    end

    // Next-state: line conditions first, then per-state bit handling
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        sda_d      = sda_q;
        pend_d     = pend_q;
        hold_d     = hold_q;
        ack_d      = ack_q;
        rx_valid_d = 1'b0;
        tx_load_d  = 1'b0;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        nack_d     = 1'b0;
        drive      = 1'b0;
        drive_val  = 1'b1;

        if (hold_q != 4'd0) begin
            hold_d = hold_q - 4'd1;
            if (hold_q == 4'd1) sda_d = pend_q;
        end

        if (start_c) begin
            start_d = 1'b1;
            sda_d   = 1'b1;
            hold_d  = 4'd0;
            cnt_d   = 4'd0;
            busy_d  = 1'b0;
            state_d = StAddr;
        end else if (stop_c) begin
            stop_d  = 1'b1;
            sda_d   = 1'b1;
            hold_d  = 4'd0;
            busy_d  = 1'b0;
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: ;
                StAddr: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_inc;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            if (shift_q[6:0] == SLAVE_ADDR) begin
                                rw_d    = sda_s;
                                busy_d  = 1'b1;
                                state_d = StAddrAck;
                            end else begin
                                state_d = StIgnore;
                            end
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_rise) cnt_d = cnt_inc;
                    if (scl_fall) begin
                        // First fall opens the ACK slot; second fall closes it
                        if (cnt_q == 4'd0) begin
                            drive     = 1'b1;
                            drive_val = ~ack_en_i;
                            ack_d     = ack_en_i;
                        end else begin
                            cnt_d = 4'd0;
                            drive = 1'b1;
                            if (!ack_q) begin
                                state_d = StIgnore;
                            end else if (!rw_q) begin
                                state_d = StRx;
                            end else begin
                                tx_shift_d = tx_data_i;
                                tx_load_d  = 1'b1;
                                drive_val  = tx_data_i[7];
                                state_d    = StTx;
                            end
                        end
                    end
                end
                StRx: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_inc;
                        if (cnt_q == 4'd7) begin
                            rx_data_d  = {shift_q[6:0], sda_s};
                            rx_valid_d = 1'b1;
                            cnt_d      = 4'd0;
                            state_d    = StRxAck;
                        end
                    end
                end
                StRxAck: begin
                    if (scl_rise) cnt_d = cnt_inc;
                    if (scl_fall) begin
                        drive = 1'b1;
                        if (cnt_q == 4'd0) begin
                            drive_val = ~ack_en_i;
                            ack_d     = ack_en_i;
                        end else begin
                            cnt_d   = 4'd0;
                            state_d = ack_q ? StRx : StIgnore;
                        end
                    end
                end
                StTx: begin
                    if (scl_rise) cnt_d = cnt_inc;
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            drive   = 1'b1;
                            cnt_d   = 4'd0;
                            state_d = StTxAck;
                        end else if (cnt_q != 4'd0) begin
                            drive      = 1'b1;
                            drive_val  = tx_shift_q[6];
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        end
                    end
                end
                StTxAck: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            nack_d  = 1'b1;
                            state_d = StIgnore;
                        end else begin
                            cnt_d = 4'd1;
                        end
                    end
                    if (scl_fall && cnt_q == 4'd1) begin
                        tx_shift_d = tx_data_i;
                        tx_load_d  = 1'b1;
                        drive      = 1'b1;
                        drive_val  = tx_data_i[7];
                        cnt_d      = 4'd0;
                        state_d    = StTx;
                    end
                end
                StIgnore: begin
                    sda_d  = 1'b1;
                    hold_d = 4'd0;
                end
                default: state_d = StIdle;
            endcase
        end

        if (drive) begin
            pend_d = drive_val;
            hold_d = HoldInit;
        end
    end

    assign sda_o       = sda_q;
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign tx_load_o   = tx_load_q;
    assign rw_o        = rw_q;
    assign busy_o      = busy_q;
    assign start_det_o = start_q;
    assign stop_det_o  = stop_q;
    assign nack_o      = nack_q;

endmodule

// File: tb/tb_i2c_slave_data_path_block.sv
// Bench for i2c_slave_data_path_block: bit-banged I2C master with directed and
// randomized transactions, expectations computed from transaction-level rules.
module tb_i2c_slave_data_path_block;

    localparam int Q = 8;  // core cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       msda = 1'b1;
    logic       ack_en = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_o, tx_load, rx_valid, rw, busy, start_det, stop_det, nack;
    logic [7:0] rx_data;
    logic       sda_line;

    assign sda_line = msda & sda_o;

    i2c_slave_data_path_block #(.SLAVE_ADDR(7'h50), .SDA_HOLD(2)) dut (
        .i2c_core_clock_i(clk),
        .reset_bit_i     (rst),
        .scl_i           (scl),
        .sda_i           (sda_line),
        .sda_o           (sda_o),
        .ack_en_i        (ack_en),
        .tx_data_i       (tx_data),
        .tx_load_o       (tx_load),
        .rx_data_o       (rx_data),
        .rx_valid_o      (rx_valid),
        .rw_o            (rw),
        .busy_o          (busy),
        .start_det_o     (start_det),
        .stop_det_o      (stop_det),
        .nack_o          (nack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_rxv = 0, n_load = 0, n_nack = 0, n_start = 0, n_stop = 0, n_low = 0;

    // Event counters; scenarios compare deltas
    always @(negedge clk) begin
        if (rx_valid)  n_rxv   <= n_rxv + 1;
        if (tx_load)   n_load  <= n_load + 1;
        if (nack)      n_nack  <= n_nack + 1;
        if (start_det) n_start <= n_start + 1;
        if (stop_det)  n_stop  <= n_stop + 1;
        if (!sda_o)    n_low   <= n_low + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start;
        if (!scl) begin
            msda = 1'b1; cyc(Q);
            scl  = 1'b1; cyc(Q);
        end
        msda = 1'b0; cyc(Q);
        scl  = 1'b0; cyc(Q);
    endtask

    task automatic do_stop;
        msda = 1'b0; cyc(Q);
        scl  = 1'b1; cyc(Q);
        msda = 1'b1; cyc(2 * Q);
    endtask

    task automatic put_bit(input logic b);
        cyc(Q); msda = b;
        cyc(Q); scl = 1'b1;
        cyc(2 * Q); scl = 1'b0;
    endtask

    task automatic get_bit(output logic b);
        msda = 1'b1;
        cyc(2 * Q); scl = 1'b1;
        cyc(Q); b = sda_line;
        cyc(Q); scl = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
    endtask

    task automatic get_byte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
    endtask

    initial begin
        logic       b, r, acked;
        logic [6:0] a;
        logic [7:0] d, last;
        logic [7:0] txv [3];
        int         n, rv0, ld0, nk0, st0, sp0, lo0;

        // Reset values
        cyc(3);
        check("rst_sda", sda_o, 1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rw", rw, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {start_det, stop_det, rx_valid, tx_load, nack}, 0);
        rst = 1'b0;
        cyc(4);

        // Write 0xA0 then 0xA5, ACKed
        rv0 = n_rxv; st0 = n_start; sp0 = n_stop;
        do_start;
        put_byte(8'hA0); get_bit(b); check("wr_addr_ack", b, 0);
        put_byte(8'hA5); get_bit(b); check("wr_data_ack", b, 0);
        check("wr_rx_data", rx_data, 8'hA5);
        check("wr_rx_valid_cnt", n_rxv - rv0, 1);
        check("wr_rw", rw, 0);
        check("wr_busy", busy, 1);
        check("wr_start_cnt", n_start - st0, 1);
        do_stop;
        check("wr_stop_cnt", n_stop - sp0, 1);
        check("wr_busy_after_stop", busy, 0);

        // Non-matching address 0x51
        rv0 = n_rxv; lo0 = n_low;
        do_start;
        put_byte(8'hA2); get_bit(b); check("mis_addr_nack", b, 1);
        put_byte(8'h5A); get_bit(b); check("mis_data_nack", b, 1);
        check("mis_busy", busy, 0);
        check("mis_rx_valid_cnt", n_rxv - rv0, 0);
        check("mis_sda_never_low", n_low - lo0, 0);
        do_stop;

        // Read two bytes 0x3C, 0xC3; master ACKs then NACKs
        ld0 = n_load; nk0 = n_nack;
        tx_data = 8'h3C;
        do_start;
        put_byte(8'hA1); get_bit(b); check("rd_addr_ack", b, 0);
        check("rd_rw", rw, 1);
        get_byte(d); check("rd_byte0", d, 8'h3C);
        tx_data = 8'hC3;
        put_bit(1'b0);
        get_byte(d); check("rd_byte1", d, 8'hC3);
        put_bit(1'b1);
        cyc(Q);
        check("rd_load_cnt", n_load - ld0, 2);
        check("rd_nack_cnt", n_nack - nk0, 1);
        check("rd_sda_released", sda_o, 1);
        do_stop;

        // Repeated START after a write byte, then read
        do_start;
        put_byte(8'hA0); get_bit(b); check("rs_addr_ack", b, 0);
        put_byte(8'h5A); get_bit(b); check("rs_data_ack", b, 0);
        st0 = n_start;
        tx_data = 8'($urandom);
        do_start;
        check("rs_start_cnt", n_start - st0, 1);
        put_byte(8'hA1); get_bit(b); check("rs_addr2_ack", b, 0);
        check("rs_rw", rw, 1);
        get_byte(d); check("rs_tx_byte", d, tx_data);
        put_bit(1'b1);
        do_stop;

        // STOP after 4 data bits
        do_start;
        put_byte(8'hA0); get_bit(b); check("ps_addr_ack", b, 0);
        rv0 = n_rxv; sp0 = n_stop;
        for (int i = 0; i < 4; i++) put_bit(1'($urandom_range(0, 1)));
        do_stop;
        check("ps_rx_valid_cnt", n_rxv - rv0, 0);
        check("ps_stop_cnt", n_stop - sp0, 1);
        check("ps_sda", sda_o, 1);
        check("ps_busy", busy, 0);

        // Asynchronous reset while the ACK is driven low
        do_start;
        put_byte(8'hA0);
        msda = 1'b1;
        cyc(2 * Q);
        check("ar_ack_driven", sda_o, 0);
        #2 rst = 1'b1;
        #1;
        check("ar_sda_released", sda_o, 1);
        check("ar_busy", busy, 0);
        check("ar_rx_data", rx_data, 8'h00);
        cyc(2);
        rst = 1'b0;
        cyc(4);
        d = 8'($urandom);
        do_start;
        put_byte(8'hA0); get_bit(b); check("ar_next_addr_ack", b, 0);
        put_byte(d); get_bit(b); check("ar_next_data_ack", b, 0);
        check("ar_next_rx_data", rx_data, d);
        do_stop;

        // ack_en low on a matched write
        ack_en = 1'b0;
        rv0 = n_rxv; lo0 = n_low;
        do_start;
        put_byte(8'hA0); get_bit(b); check("ne_addr_nack", b, 1);
        put_byte(8'h81); get_bit(b); check("ne_data_nack", b, 1);
        check("ne_rx_valid_cnt", n_rxv - rv0, 0);
        check("ne_sda_never_low", n_low - lo0, 0);
        do_stop;
        ack_en = 1'b1;

        // Randomized transactions against the transaction-level model
        for (int t = 0; t < 8; t++) begin
            ack_en = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 1) == 1) ? 7'h50 : 7'($urandom_range(0, 127));
            r = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            acked = (a == 7'h50) && ack_en;
            for (int k = 0; k < 3; k++) txv[k] = 8'($urandom);
            tx_data = txv[0];
            rv0 = n_rxv; ld0 = n_load; nk0 = n_nack; sp0 = n_stop;
            last = 8'h00;
            do_start;
            put_byte({a, r}); get_bit(b); check("rnd_addr_ack", b, !acked);
            if (!r) begin
                for (int k = 0; k < n; k++) begin
                    d = 8'($urandom);
                    put_byte(d); get_bit(b); check("rnd_data_ack", b, !acked);
                    last = d;
                end
                if (acked) check("rnd_rx_data", rx_data, last);
                check("rnd_rx_valid_cnt", n_rxv - rv0, acked ? n : 0);
            end else if (acked) begin
                for (int k = 0; k < n; k++) begin
                    get_byte(d); check("rnd_tx_byte", d, txv[k]);
                    if (k < n - 1) tx_data = txv[k + 1];
                    put_bit(k == n - 1);
                end
                check("rnd_load_cnt", n_load - ld0, n);
                check("rnd_nack_cnt", n_nack - nk0, 1);
            end
            do_stop;
            check("rnd_stop_cnt", n_stop - sp0, 1);
            check("rnd_busy", busy, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
